// File: rtl/accel_cmd_seq.sv
// Command sequencer: buffers {A,B,op} commands and replays each as ALU register-bus writes/read.
// Latency: 6 cycles from command accept to res_valid; one result per 6 cycles when res_ready stays high.
// Backpressure: cmd_ready drops when the FIFO is full; the FSM holds in HOLD until res_ready. Option: ACCEL_SEQ_CHAIN_EN.

module accel_cmd_seq_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dat_o   = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= dat_i;
    end
endmodule

module accel_cmd_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    input  logic       cmd_chain,
    output logic [3:0] acc_address,
    output logic       acc_data_write,
    output logic [7:0] acc_data_in,
    input  logic [7:0] acc_data_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_RD_RES, S_HOLD
    } state_t;

`ifdef ACCEL_SEQ_CHAIN_EN
    localparam int CW = 21;
`else
    localparam int CW = 20;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [7:0]    res_q, res_d;
    logic [CW-1:0] fifo_wdat, fifo_rdat;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [7:0]    a_wr;

`ifdef ACCEL_SEQ_CHAIN_EN
    logic [7:0] last_q, last_d;
    assign fifo_wdat = {cmd_chain, cmd_op, cmd_b, cmd_a};
    assign a_wr      = cmd_q[20] ? last_q : cmd_q[7:0];
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign fifo_wdat    = {cmd_op, cmd_b, cmd_a};
    assign a_wr         = cmd_q[7:0];
`endif

    accel_cmd_seq_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .dat_i   (fifo_wdat),
        .pop_i   (fifo_pop),
        .dat_o   (fifo_rdat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign res_valid = (state_q == S_HOLD);
    assign res_data  = res_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            res_q   <= '0;
`ifdef ACCEL_SEQ_CHAIN_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
`ifdef ACCEL_SEQ_CHAIN_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        res_d   = res_q;
`ifdef ACCEL_SEQ_CHAIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d   = fifo_rdat;
                    state_d = S_WR_A;
                end
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_OP;
            S_WR_OP: state_d = S_RD_RES;
            S_RD_RES: begin
                res_d   = acc_data_out;
`ifdef ACCEL_SEQ_CHAIN_EN
                last_d  = acc_data_out;
`endif
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs depend only on registered state so nothing upstream reaches the accelerator combinationally.
    always_comb begin
        acc_address    = 4'h5;
        acc_data_write = 1'b0;
        acc_data_in    = 8'h00;
        case (state_q)
            S_WR_A: begin
                acc_address    = 4'h0;
                acc_data_write = 1'b1;
                acc_data_in    = a_wr;
            end
            S_WR_B: begin
                acc_address    = 4'h1;
                acc_data_write = 1'b1;
                acc_data_in    = cmd_q[15:8];
            end
            S_WR_OP: begin
                acc_address    = 4'h4;
                acc_data_write = 1'b1;
                acc_data_in    = {4'b0, cmd_q[19:16]};
            end
            default: ;
        endcase
    end
endmodule
